// File: rtl/clock_group_seq_pkg.sv
// Shared types and constants for the clock-group reset sequencer.
//   seq_state_e : sequencer state (hold, staggered release, idle)
//   MAX_GROUPS  : largest number of groups the sequencer supports
//   IDX_W       : width of a group index, sized for MAX_GROUPS
package clock_group_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_IDLE    = 2'd2
  } seq_state_e;

  localparam int MAX_GROUPS = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  localparam int IDX_W = clog2(MAX_GROUPS);

endpackage

// File: rtl/clock_group_reset_sequencer_next_set_bit.sv
// next_set_bit: combinational search for a set bit in a mask.
//   mask       : bits to search
//   start      : search strictly above this index (ignored when start_none)
//   start_none : search from the bottom, returning the lowest set bit
//   idx        : index of the bit found (0 when none)
//   found      : a qualifying bit exists
module next_set_bit
  import clock_group_seq_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     mask,
  input  logic [IDX_W-1:0] start,
  input  logic             start_none,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scanning downward lets the lowest qualifying bit overwrite any higher one.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && (start_none || (IDX_W'(i) > start))) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer: holds all group resets after power-on, then
// releases the groups one at a time (lowest index first) with a fixed
// stagger. Software can re-reset a subset of groups via a valid/ready request.
//
// Ports:
//   clock          : block clock
//   reset          : asynchronous active-low reset
//   req_valid      : re-reset request valid
//   req_ready      : high in IDLE; request accepted on valid & ready
//   req_mask       : groups to re-reset (sampled on accept only)
//   group_reset    : registered active-high per-group reset
//   group_clock_en : per-group clock enable
//   seq_busy       : high in HOLD or RELEASE
//   seq_done       : one-cycle pulse when a release sequence completes
//
// Build option: define CLOCK_GROUP_SEQ_GATE_EN to gate the clocks of the
// sequenced groups during the first half of HOLD. Without it group_clock_en
// is tied high.
module clock_group_reset_sequencer
  import clock_group_seq_pkg::*;
#(
  parameter int NUM_GROUPS     = 2,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [NUM_GROUPS-1:0] req_mask,
  output logic [NUM_GROUPS-1:0] group_reset,
  output logic [NUM_GROUPS-1:0] group_clock_en,
  output logic                  seq_busy,
  output logic                  seq_done
);

  localparam logic [CNT_W-1:0] HOLD_END    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_END = CNT_W'(STAGGER_CYCLES - 1);

  seq_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_GROUPS-1:0] active_mask_q, active_mask_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_GROUPS-1:0] group_reset_q, group_reset_d;
  logic                  seq_done_q, seq_done_d;

  logic [IDX_W-1:0]      nsb_idx;
  logic                  nsb_found;

  // In HOLD the search picks the first group; in RELEASE it picks the one
  // after the group released most recently.
  next_set_bit #(
    .N (NUM_GROUPS)
  ) u_next_set_bit (
    .mask       (active_mask_q),
    .start      (idx_q),
    .start_none (state_q == ST_HOLD),
    .idx        (nsb_idx),
    .found      (nsb_found)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_mask_d = active_mask_q;
    idx_d         = idx_q;
    group_reset_d = group_reset_q;
    seq_done_d    = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_END) begin
          cnt_d = '0;
          idx_d = nsb_idx;
          if (nsb_found) begin
            state_d = ST_RELEASE;
            for (int i = 0; i < NUM_GROUPS; i++) begin
              if (IDX_W'(i) == nsb_idx) group_reset_d[i] = 1'b0;
            end
          end else begin
            // Unreachable with a non-empty mask; fall back to idle safely.
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RELEASE: begin
        if (cnt_q == STAGGER_END) begin
          cnt_d = '0;
          if (nsb_found) begin
            idx_d = nsb_idx;
            for (int i = 0; i < NUM_GROUPS; i++) begin
              if (IDX_W'(i) == nsb_idx) group_reset_d[i] = 1'b0;
            end
          end else begin
            state_d    = ST_IDLE;
            seq_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_IDLE: begin
        // An empty mask is accepted but leaves the sequencer idle.
        if (req_valid && (req_mask != '0)) begin
          active_mask_d = req_mask;
          group_reset_d = req_mask;
          cnt_d         = '0;
          state_d       = ST_HOLD;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_HOLD;
      cnt_q         <= '0;
      active_mask_q <= '1;
      idx_q         <= '0;
      group_reset_q <= '1;
      seq_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_mask_q <= active_mask_d;
      idx_q         <= idx_d;
      group_reset_q <= group_reset_d;
      seq_done_q    <= seq_done_d;
    end
  end

  assign group_reset = group_reset_q;
  assign seq_done    = seq_done_q;
  assign req_ready   = (state_q == ST_IDLE);
  assign seq_busy    = (state_q != ST_IDLE);

`ifdef CLOCK_GROUP_SEQ_GATE_EN
  localparam logic [CNT_W-1:0] GATE_END = CNT_W'(HOLD_CYCLES / 2);

  // Sequenced groups have their clocks stopped for the first half of HOLD,
  // then running again so the reset is seen by a live clock at release.
  always_comb begin
    group_clock_en = '1;
    if ((state_q == ST_HOLD) && (cnt_q < GATE_END)) begin
      group_clock_en = ~active_mask_q;
    end
  end
`else
  assign group_clock_en = '1;
`endif

endmodule
